// File: rtl/krv_dmem_responder_if.sv
// Request/response bus between the CPU load/store unit and the data-memory responder.
interface krv_dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    // Requester side (CPU).
    modport master (
        output req_valid, req_we, req_size, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    // Responder side (data memory).
    modport slave (
        input  req_valid, req_we, req_size, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/krv_dmem_responder.sv
// Byte-addressed big-endian data memory with valid/ready request and response channels,
// optional wait states, and an active-low LED drive taken from data byte offset 3.
module krv_dmem_responder #(
    parameter int unsigned BASE_ADDR   = 2000,
    parameter int unsigned DEPTH       = 32,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned LED_WIDTH   = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    krv_dmem_responder_if.slave      bus,
    output logic [LED_WIDTH-1:0]     LEDS
);

    localparam int unsigned AW = $clog2(DEPTH);
    // Last counter value spent in WAIT; unused when WAIT_CYCLES is 0.
    localparam logic [3:0] WAIT_LAST = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;
    logic [7:0]  mem_q [DEPTH];
    logic [7:0]  mem_d [DEPTH];

    logic [31:0]   off;
    logic [32:0]   end_off;
    logic [2:0]    nbytes;
    logic          size_err;
    logic          range_err;
    logic          align_err;
    logic          acc_err;
    logic [AW-1:0] idx0, idx1, idx2, idx3;
    logic [31:0]   load_data;

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

    assign LEDS = ~mem_q[3][LED_WIDTH-1:0];

    // Decode the latched request: offset, access width, error checks and load data.
    always_comb begin
        // Wrap-around subtraction makes below-base addresses huge so they fail the range check.
        off = addr_q - BASE_ADDR;
        unique case (size_q)
            SZ_BYTE: nbytes = 3'd1;
            SZ_HALF: nbytes = 3'd2;
            default: nbytes = 3'd4;
        endcase
        // One extra bit so offsets near 2^32 cannot wrap back into range.
        end_off   = {1'b0, off} + 33'(nbytes);
        size_err  = (size_q == 2'b11);
        range_err = (end_off > 33'(DEPTH));
        align_err = ((size_q == SZ_HALF) && off[0]) ||
                    ((size_q == SZ_WORD) && (off[1:0] != 2'b00));
        acc_err   = size_err || range_err || align_err;

        idx0 = off[AW-1:0];
        idx1 = off[AW-1:0] + AW'(1);
        idx2 = off[AW-1:0] + AW'(2);
        idx3 = off[AW-1:0] + AW'(3);

        unique case (size_q)
            SZ_BYTE: load_data = {24'h0, mem_q[idx0]};
            SZ_HALF: load_data = {16'h0, mem_q[idx0], mem_q[idx1]};
            default: load_data = {mem_q[idx0], mem_q[idx1], mem_q[idx2], mem_q[idx3]};
        endcase
    end

    // Next-state logic: FSM, request latch, wait counter, response and memory write.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        size_d      = size_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        mem_d       = mem_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    size_d  = bus.req_size;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    cnt_d   = 4'd0;
                    state_d = (WAIT_CYCLES > 0) ? ST_WAIT : ST_ACCESS;
                end
            end
            ST_WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    cnt_d   = 4'd0;
                    state_d = ST_ACCESS;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_ACCESS: begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = acc_err;
                rsp_rdata_d = (we_q || acc_err) ? 32'h0 : load_data;
                if (we_q && !acc_err) begin
                    unique case (size_q)
                        SZ_BYTE: begin
                            mem_d[idx0] = wdata_q[7:0];
                        end
                        SZ_HALF: begin
                            mem_d[idx0] = wdata_q[15:8];
                            mem_d[idx1] = wdata_q[7:0];
                        end
                        default: begin
                            mem_d[idx0] = wdata_q[31:24];
                            mem_d[idx1] = wdata_q[23:16];
                            mem_d[idx2] = wdata_q[15:8];
                            mem_d[idx3] = wdata_q[7:0];
                        end
                    endcase
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = 32'h0;
                    rsp_err_d   = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control, request and response registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            size_q      <= 2'b00;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            size_q      <= size_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Data memory; reset clears every byte so the LEDs come up off.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

endmodule

// File: doc/krv_dmem_responder.md
Name: krv_dmem_responder

Overview:
- Bus-side responder for the KRV-32 data/IO space: a byte-addressed data memory of DEPTH bytes, decoded at BASE_ADDR, that answers load/store requests from the CPU core.
- Implements a valid/ready request channel and a valid/ready response channel, with configurable wait states.
- Drives the board LEDs from data byte offset 3 (address 2003).
- Sits between the CPU load/store unit and the Tang-9 LED pins.

Parameters:
BASE_ADDR, 2000, first byte address decoded by this block
DEPTH, 32, data memory size in bytes (power of two, >=4)
WAIT_CYCLES, 1, wait states inserted between request accept and memory access (0..15)
LED_WIDTH, 6, number of LED outputs

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request
req_we  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 half, 10 word, 11 illegal
req_addr  input  32  byte address
req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
rsp_valid  output  1  response present
rsp_ready  input  1  requester accepts the response
rsp_rdata  output  32  load data, zero-extended and right-aligned; 0 for stores and errors
rsp_err  output  1  access rejected
LEDS  output  LED_WIDTH  active-low LED drive, equal to ~mem[3][LED_WIDTH-1:0]

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0.
  - All DEPTH memory bytes cleared to 0, so LEDS reset to all-ones (LEDs off).
- States and transitions:
  - IDLE: req_ready=1. When req_valid is sampled high, latch we/size/addr/wdata and go to WAIT if WAIT_CYCLES>0, otherwise to ACCESS.
  - WAIT: req_ready=0. Counter runs 0..WAIT_CYCLES-1, then goes to ACCESS.
  - ACCESS: req_ready=0. Performs the check and the memory operation on this edge, registers rsp_rdata/rsp_err, sets rsp_valid=1, and goes to RESP.
  - RESP: req_ready=0. rsp_valid, rsp_rdata and rsp_err are held stable until rsp_valid && rsp_ready is sampled. On that edge: rsp_valid=0, rsp_rdata=0, rsp_err=0, and go to IDLE.
- Latency: if a request is accepted on edge E0, rsp_valid is high after edge E0+WAIT_CYCLES+1. If rsp_ready is held high, the next request can be accepted at E0+WAIT_CYCLES+3.
- req_ready is a combinational decode of state==IDLE. Inputs are ignored outside IDLE, and a request present during RESP is not lost: it is accepted in IDLE if still valid.
- Address math: off = req_addr - BASE_ADDR, 32-bit unsigned (wrap-around). Below-base addresses therefore produce huge offsets and fail the range check.
- Error conditions (rsp_err=1, no memory write, rsp_rdata=0):
  - req_size==11;
  - off+nbytes > DEPTH, where nbytes = 1/2/4;
  - misalignment: half with off[0]!=0, or word with off[1:0]!=0.
- Byte order is big-endian:
  - word: mem[off]=data[31:24], mem[off+1]=[23:16], mem[off+2]=[15:8], mem[off+3]=[7:0];
  - half: mem[off]=[15:8], mem[off+1]=[7:0];
  - byte: mem[off]=[7:0].
- Stores write only the addressed bytes; other bytes are untouched.
- Loads: rsp_rdata is the addressed bytes in the same order, zero-extended to 32 bits.
- LEDS is combinational from mem[3] and updates the cycle after a store to offset 3 completes in ACCESS.
- Reset during WAIT or RESP aborts the transaction: no write occurs and rsp_valid drops immediately. Reset during ACCESS: the asynchronous clear wins, so memory is all zeros.

Test Plan:
- Store word 0xDEADBEEF at 2004, then load word from 2004. Required: both responses have rsp_err=0, load rsp_rdata=0xDEADBEEF. Then load byte from 2005 gives rsp_rdata=0x000000AD; load half from 2006 gives 0x0000BEEF.
- Store byte 0x15 at 2003. Required: LEDS=6'h2A one cycle after ACCESS; bytes 2000-2002 remain 0, so a word load from 2000 returns 0x00000015.
- Word load at 2002, half store at 2001, req_size=11 at 2000. Required: each gives rsp_err=1, rsp_rdata=0, and no memory change.
- Load word at 1999, 2028 and 2032 (DEPTH=32). Required: rsp_err=1 for 1999 and 2032; 2028 succeeds.
- WAIT_CYCLES=3, request accepted at edge E0 with rsp_ready held low for 5 cycles. Required: rsp_valid high from E0+4 with data stable, req_ready=0 throughout, then a return to IDLE one edge after rsp_ready rises.
- Store word issued, rst pulsed low during WAIT. Required: rsp_valid=0, req_ready=1, LEDS=6'h3F immediately, and a subsequent load of that address returns 0.
